// File: rtl/mem_bus_arbiter.sv
// ----------------------------------------------------------------------------
// mem_bus_arbiter
//
// Shares a single sram-like memory bus (req / addr_ok / data_ok handshake,
// one outstanding transaction at a time) between the IF-stage instruction
// fetch and the MEM-stage data access. Each side sees a stall until its
// access has completed. The returned word is held until the pipeline
// advances. A fetch that was already launched when a flush arrives runs to
// completion on the bus, and its response is then dropped.
//
// Ports
//   clk, rst        : clock, asynchronous active-high reset
//   inst_req        : fetch request (InstEnableF)
//   inst_addr       : fetch address (PCF)
//   inst_rdata      : fetched word, held while the fetch is done
//   inst_stall      : fetch not yet complete
//   data_req        : data access request (MemEnableM)
//   data_wen        : byte write enables, 0 = read
//   data_addr       : data address
//   data_wdata      : store data
//   data_rdata      : load word, held while the data access is done
//   data_stall      : data access not yet complete
//   pipe_hold       : stall raised by other sources (MDU busy, load-use)
//   flush           : exception / eret redirect, cancels an unfinished fetch
//   bus_req         : bus request (high only while waiting for addr_ok)
//   bus_wr          : 1 = write
//   bus_wstrb       : byte strobes
//   bus_addr        : bus address
//   bus_wdata       : bus write data
//   bus_addr_ok     : address accepted this cycle
//   bus_data_ok     : response valid this cycle
//   bus_rdata       : read data
// ----------------------------------------------------------------------------
module mem_bus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic [DATA_W-1:0] inst_rdata,
    output logic              inst_stall,

    input  logic              data_req,
    input  logic [3:0]        data_wen,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic [DATA_W-1:0] data_rdata,
    output logic              data_stall,

    input  logic              pipe_hold,
    input  logic              flush,

    output logic              bus_req,
    output logic              bus_wr,
    output logic [3:0]        bus_wstrb,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok,
    input  logic [DATA_W-1:0] bus_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } state_e;

    localparam logic GRANT_INST = 1'b0;
    localparam logic GRANT_DATA = 1'b1;

    state_e            state_q, state_d;
    logic              grant_q, grant_d;
    logic              cancel_q, cancel_d;
    logic              inst_done_q, inst_done_d;
    logic              data_done_q, data_done_d;
    logic [DATA_W-1:0] inst_rdata_q, inst_rdata_d;
    logic [DATA_W-1:0] data_rdata_q, data_rdata_d;

    logic inst_pend;
    logic data_pend;
    logic advance;
    logic data_is_read;
    logic bus_is_data;

    // A flushed fetch must not start a new transaction this cycle; the
    // redirected PC shows up on the next cycle.
    assign inst_pend    = inst_req & ~inst_done_q & ~flush;
    assign data_pend    = data_req & ~data_done_q;

    assign inst_stall   = inst_req & ~inst_done_q;
    assign data_stall   = data_req & ~data_done_q;

    // The whole pipeline moves on this cycle, so both results are consumed
    // and the next instructions must arbitrate again.
    assign advance      = ~inst_stall & ~data_stall & ~pipe_hold;

    assign data_is_read = (data_wen == 4'b0000);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            grant_q      <= GRANT_INST;
            cancel_q     <= 1'b0;
            inst_done_q  <= 1'b0;
            data_done_q  <= 1'b0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            cancel_q     <= cancel_d;
            inst_done_q  <= inst_done_d;
            data_done_q  <= data_done_d;
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        cancel_d     = cancel_q;
        inst_done_d  = inst_done_q;
        data_done_d  = data_done_q;
        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;

        if (advance) begin
            inst_done_d = 1'b0;
            data_done_d = 1'b0;
        end

        // The redirected fetch stream must not see a stale completed word.
        if (flush) begin
            inst_done_d = 1'b0;
        end

        unique case (state_q)
            S_IDLE: begin
                // MEM holds the older instruction, so it wins a tie.
                if (data_pend) begin
                    state_d = S_ADDR;
                    grant_d = GRANT_DATA;
                end else if (inst_pend) begin
                    state_d = S_ADDR;
                    grant_d = GRANT_INST;
                end
            end

            S_ADDR: begin
                // The bus has no abort, so a flushed fetch still runs to
                // completion; remember to drop its response.
                if (flush && grant_q == GRANT_INST) begin
                    cancel_d = 1'b1;
                end
                if (bus_addr_ok) begin
                    state_d = S_DATA;
                end
            end

            S_DATA: begin
                if (flush && grant_q == GRANT_INST) begin
                    cancel_d = 1'b1;
                end
                if (bus_data_ok) begin
                    state_d = S_IDLE;
                    if (grant_q == GRANT_INST) begin
                        // A flush in the response cycle itself also discards.
                        if (cancel_q || flush) begin
                            cancel_d = 1'b0;
                        end else begin
                            inst_rdata_d = bus_rdata;
                            inst_done_d  = 1'b1;
                        end
                    end else begin
                        if (data_is_read) begin
                            data_rdata_d = bus_rdata;
                        end
                        data_done_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Bus side
    // ------------------------------------------------------------------
    // bus_req is a pure state decode, so it rises the cycle after the
    // request. The requester holds its inputs while stalled, so the bus
    // fields can come straight from its live inputs. They are forced to zero
    // whenever no request is presented.
    assign bus_req     = (state_q == S_ADDR);
    assign bus_is_data = bus_req & (grant_q == GRANT_DATA);

    assign bus_wr      = bus_is_data & ~data_is_read;
    assign bus_wstrb   = bus_is_data ? data_wen   : 4'b0000;
    assign bus_wdata   = bus_is_data ? data_wdata : '0;
    assign bus_addr    = bus_req ? (bus_is_data ? data_addr : inst_addr) : '0;

    assign inst_rdata  = inst_rdata_q;
    assign data_rdata  = data_rdata_q;

endmodule
